// File: rtl/serial_word_deserializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ser_deser_pkg : FSM state encoding and line-level constants               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package ser_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ser_state_t;

  localparam logic SER_START_BIT = 1'b0;
  localparam logic SER_STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_word_deserializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_word_deserializer_if : serial input side and parallel word output  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface serial_word_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             bit_valid;
  logic             serial_in;
  logic             abort;
  logic [WIDTH-1:0] data_out;
  logic             load;
  logic             busy;
  logic             frame_err;
  logic             parity_err;

  modport master (
    output bit_valid, serial_in, abort,
    input  data_out, load, busy, frame_err, parity_err
  );

  modport slave (
    input  bit_valid, serial_in, abort,
    output data_out, load, busy, frame_err, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_deserializer_bit_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ser_bit_counter : clear/enable data-bit counter, terminal count at WIDTH-1|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ser_bit_counter #(
  parameter int WIDTH = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_clr,
  input  wire  i_en,
  output logic o_tc
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc = (r_count == c_last);
  assign o_tc = w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_tc ? '0 : r_count + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_word_deserializer : framed serial stream to WIDTH-bit word + load  |
// | Optional even parity bit: define SER_DESER_PARITY_EN.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module serial_word_deserializer
  import ser_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input wire                        clk,
  input wire                        reset_n,
  serial_word_deserializer_if.slave bus
);
  localparam logic [1:0] c_st_idle   = IDLE;
  localparam logic [1:0] c_st_data   = DATA;
  localparam logic [1:0] c_st_parity = PARITY;
  localparam logic [1:0] c_st_stop   = STOP;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] r_data_out;
  logic             r_load;
  logic             r_busy;
  logic             r_frame_err;
  logic             w_tc;
  logic             w_start;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_par_fail;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], bus.serial_in};
    end else begin : g_lsb_first
      assign w_shift_next = {bus.serial_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_start   = (r_state == c_st_idle) && bus.bit_valid && (bus.serial_in == SER_START_BIT);
  assign w_cnt_clr = bus.abort || w_start;
  assign w_cnt_en  = !bus.abort && bus.bit_valid && (r_state == c_st_data);

  ser_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst_n (reset_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

`ifdef SER_DESER_PARITY_EN
  logic r_par_err;
  logic r_parity_err;
  assign w_par_fail     = r_par_err;
  assign bus.parity_err = r_parity_err;
`else
  assign w_par_fail     = 1'b0;
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_st_idle;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_load      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SER_DESER_PARITY_EN
      r_par_err    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SER_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // abort wins over a coincident strobe; data_out is deliberately kept
      if (bus.abort) begin
        r_state <= c_st_idle;
        r_busy  <= 1'b0;
      end else if (bus.bit_valid) begin
        case (r_state)
          c_st_idle: begin
            if (bus.serial_in == SER_START_BIT) begin
              r_state <= c_st_data;
              r_busy  <= 1'b1;
            end
          end
          c_st_data: begin
            r_shift <= w_shift_next;
            if (w_tc) begin
`ifdef SER_DESER_PARITY_EN
              r_state <= c_st_parity;
`else
              r_state <= c_st_stop;
`endif
            end
          end
          c_st_parity: begin
`ifdef SER_DESER_PARITY_EN
            r_par_err <= ^{r_shift, bus.serial_in};
            r_state   <= c_st_stop;
`else
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
`endif
          end
          c_st_stop: begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
            if (bus.serial_in != SER_STOP_BIT) begin
              r_frame_err <= 1'b1;
            end
`ifdef SER_DESER_PARITY_EN
            r_parity_err <= r_par_err;
`endif
            if (bus.serial_in == SER_STOP_BIT && !w_par_fail) begin
              r_data_out <= r_shift;
              r_load     <= 1'b1;
            end
          end
          default: r_state <= c_st_idle;
        endcase
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.load      = r_load;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_word_deserializer : directed frames with hand-computed results  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_serial_word_deserializer;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   load_cnt, ferr_cnt, perr_cnt, busy_cyc;
  logic [3:0] load_data[$];
  int         load_cyc[$];

  serial_word_deserializer_if #(.WIDTH(4)) bus ();

  serial_word_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // outputs are observed on the falling edge, away from register updates
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.load) begin
        load_cnt++;
        load_data.push_back(bus.data_out);
        load_cyc.push_back(cyc);
      end
      if (bus.frame_err)  ferr_cnt++;
      if (bus.parity_err) perr_cnt++;
      if (bus.busy)       busy_cyc++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qdata(input int i);
    return (i < load_data.size()) ? 32'(load_data[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qcyc(input int i);
    return (i < load_cyc.size()) ? 32'(load_cyc[i]) : 32'hDEAD;
  endfunction

  task automatic clear_stats();
    load_cnt = 0; ferr_cnt = 0; perr_cnt = 0; busy_cyc = 0;
    load_data.delete();
    load_cyc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bus.bit_valid = 1'b1;
    bus.serial_in = b;
    tick(1);
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b1;
    if (gap > 0) tick(gap);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 4; i++) send_bit(d[i], gap);
`ifdef SER_DESER_PARITY_EN
    send_bit(par, gap);
`else
    if (par === 1'bz) $display("parity bit ignored");
`endif
    send_bit(stop, gap);
  endtask

`ifdef SER_DESER_PARITY_EN
  localparam int c_busy_len = 6;
`else
  localparam int c_busy_len = 5;
`endif

  initial begin
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b1;
    bus.abort     = 1'b0;
    clear_stats();
    tick(2);
    check_eq("rst_data_out",   32'(bus.data_out),   32'h0);
    check_eq("rst_load",       32'(bus.load),       32'h0);
    check_eq("rst_busy",       32'(bus.busy),       32'h0);
    check_eq("rst_frame_err",  32'(bus.frame_err),  32'h0);
    check_eq("rst_parity_err", 32'(bus.parity_err), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // idle-level strobes are ignored, then frame 0,1,0,1,1,1 -> 4'b1101
    clear_stats();
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    check_eq("idle_strobe_busy", 32'(bus.busy), 32'h0);
    send_frame(4'hD, ^4'hD, 1'b1, 0);
    tick(2);
    check_eq("f1_load_cnt", 32'(load_cnt), 32'd1);
    check_eq("f1_data",     qdata(0),      32'hD);
    check_eq("f1_busy_len", 32'(busy_cyc), 32'(c_busy_len));
    check_eq("f1_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // bad stop bit
    clear_stats();
    send_frame(4'h2, ^4'h2, 1'b0, 0);
    tick(2);
    check_eq("ferr_cnt",      32'(ferr_cnt),     32'd1);
    check_eq("ferr_load_cnt", 32'(load_cnt),     32'd0);
    check_eq("ferr_data_out", 32'(bus.data_out), 32'hD);

    // back-to-back frames, continuous strobes
    clear_stats();
    send_frame(4'hA, ^4'hA, 1'b1, 0);
    send_frame(4'h3, ^4'h3, 1'b1, 0);
    tick(2);
    check_eq("b2b_load_cnt", 32'(load_cnt), 32'd2);
    check_eq("b2b_data0",    qdata(0), 32'hA);
    check_eq("b2b_data1",    qdata(1), 32'h3);
    check_eq("b2b_spacing",  qcyc(1) - qcyc(0), 32'(c_busy_len + 1));

    // strobe every 3rd cycle, abort after two data bits (abort beats a start-like strobe)
    clear_stats();
    send_bit(1'b0, 2);
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    check_eq("abort_busy_before", 32'(bus.busy), 32'h1);
    bus.abort     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b0;
    tick(1);
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b1;
    check_eq("abort_busy_after", 32'(bus.busy), 32'h0);
    tick(2);
    send_frame(4'h5, ^4'h5, 1'b1, 2);
    tick(2);
    check_eq("abort_load_cnt", 32'(load_cnt), 32'd1);
    check_eq("abort_data",     qdata(0),      32'h5);
    check_eq("abort_ferr_cnt", 32'(ferr_cnt), 32'd0);

    // asynchronous reset mid-frame
    clear_stats();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",     32'(bus.busy),     32'h0);
    check_eq("mid_rst_data_out", 32'(bus.data_out), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    send_frame(4'h9, ^4'h9, 1'b1, 0);
    tick(2);
    check_eq("post_rst_load_cnt", 32'(load_cnt),     32'd1);
    check_eq("post_rst_data",     qdata(0),          32'h9);
    check_eq("post_rst_data_out", 32'(bus.data_out), 32'h9);

`ifdef SER_DESER_PARITY_EN
    clear_stats();
    send_frame(4'h7, 1'b1, 1'b1, 0);
    tick(2);
    check_eq("par_ok_load_cnt", 32'(load_cnt), 32'd1);
    check_eq("par_ok_data",     qdata(0),      32'h7);
    check_eq("par_ok_perr_cnt", 32'(perr_cnt), 32'd0);
    clear_stats();
    send_frame(4'h7, 1'b0, 1'b1, 0);
    tick(2);
    check_eq("par_bad_perr_cnt", 32'(perr_cnt),     32'd1);
    check_eq("par_bad_load_cnt", 32'(load_cnt),     32'd0);
    check_eq("par_bad_ferr_cnt", 32'(ferr_cnt),     32'd0);
    check_eq("par_bad_data_out", 32'(bus.data_out), 32'h7);
`else
    check_eq("perr_tied_low", 32'(perr_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
